// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// hazard stall/flush (bubble insertion) and a selectable capture edge.
module pipe_stage_buf #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  parameter bit                    NEG_EDGE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  // Encoding doubles as the entry count, so occupancy is just the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pop;

  assign in_ready  = (state_q != TWO) && !stall && !flush;
  assign out_valid = (state_q != EMPTY) && !stall && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = logic'(state_q[1]) ? 2'd2 : {1'b0, state_q[0]};

  // Stall needs no branch of its own: it forces push and pop low, so everything holds.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop && !push) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end else if (push && pop) begin
            main_d  = in_data;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg_edge
      always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          main_q  <= NOP_VALUE;
          skid_q  <= NOP_VALUE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          main_q  <= NOP_VALUE;
          skid_q  <= NOP_VALUE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a posedge instance for reset/stream/backpressure/
// stall/flush and a negedge instance for the capture-edge rerun, both scoreboarded.
module tb_pipe_stage_buf;

  localparam int unsigned W   = 32;
  localparam logic [W-1:0] NOP = 32'h13;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         stall = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;

  logic         n_stall = 1'b0, n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
  logic [W-1:0] n_in_data = '0;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occ;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_WIDTH(W), .NOP_VALUE(NOP), .NEG_EDGE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occ)
  );

  pipe_stage_buf #(.DATA_WIDTH(W), .NOP_VALUE(NOP), .NEG_EDGE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(n_stall), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occ)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Posedge instance: sample handshakes at the falling edge, then step past the rising edge.
  task automatic cyc0();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb0.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb0_unexpected_output observed=%h expected=none", out_data);
      end else begin
        chk("sb0_data", out_data, sb0.pop_front());
      end
    end
    if (in_valid && in_ready) sb0.push_back(in_data);
    if (flush) sb0.delete();
    @(posedge clk);
    #1;
  endtask

  // Negedge instance: nothing may change across the rising edge; sample there, then step past the falling edge.
  task automatic cyc1();
    logic [1:0]   prev_occ;
    logic [W-1:0] prev_data;
    prev_occ  = n_occ;
    prev_data = n_out_data;
    @(posedge clk);
    #1;
    chk("t6_rise_occ_hold", {30'd0, n_occ}, {30'd0, prev_occ});
    chk("t6_rise_data_hold", n_out_data, prev_data);
    if (n_out_valid && n_out_ready) begin
      if (sb1.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb1_unexpected_output observed=%h expected=none", n_out_data);
      end else begin
        chk("sb1_data", n_out_data, sb1.pop_front());
      end
    end
    if (n_in_valid && n_in_ready) sb1.push_back(n_in_data);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // T1: reset state
    #1 rst = 1'b0;
    #1;
    chk("t1_out_data", out_data, NOP);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_occ", {30'd0, occ}, 32'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // T2: streaming, one word per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      cyc0();
      chk("t2_out_data", out_data, W'(i));
      chk("t2_occ", {30'd0, occ}, 32'd1);
      chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cyc0();
    chk("t2_drain_occ", {30'd0, occ}, 32'd0);

    // T3: backpressure fills the skid entry, 0xC is refused until space opens
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cyc0();
    in_data   = 32'hB;
    cyc0();
    chk("t3_occ_full", {30'd0, occ}, 32'd2);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 32'hC;
    cyc0();
    chk("t3_occ_hold", {30'd0, occ}, 32'd2);
    chk("t3_head", out_data, 32'hA);
    out_ready = 1'b1;
    cyc0();
    cyc0();
    in_valid = 1'b0;
    cyc0();
    chk("t3_drain_occ", {30'd0, occ}, 32'd0);

    // T4: stall freezes a full stage
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cyc0();
    in_data   = 32'hB;
    cyc0();
    stall     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hD;
    for (int i = 0; i < 3; i++) begin
      cyc0();
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_occ", {30'd0, occ}, 32'd2);
      chk("t4_head", out_data, 32'hA);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    cyc0();
    chk("t4_next_head", out_data, 32'hB);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hE;
    cyc0();
    chk("t4_refill_occ", {30'd0, occ}, 32'd2);

    // T5: flush beats stall and the offered word
    flush     = 1'b1;
    stall     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hF;
    cyc0();
    chk("t5_occ", {30'd0, occ}, 32'd0);
    chk("t5_out_data", out_data, NOP);
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc0();
      chk("t5_no_ghost", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 32'h5;
    cyc0();
    in_valid = 1'b0;
    cyc0();
    chk("t5_recover_occ", {30'd0, occ}, 32'd0);

    // T1 again: async reset while two entries are held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h21;
    cyc0();
    in_data   = 32'h22;
    cyc0();
    chk("t1_pre_reset_occ", {30'd0, occ}, 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t1_mid_occ", {30'd0, occ}, 32'd0);
    chk("t1_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_mid_out_data", out_data, NOP);
    sb0.delete();
    @(posedge clk);
    #1 rst = 1'b1;

    // T6: streaming on the negedge instance
    @(negedge clk);
    #1;
    n_out_ready = 1'b1;
    n_in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      n_in_data = W'(i);
      cyc1();
      chk("t6_out_data", n_out_data, W'(i));
      chk("t6_occ", {30'd0, n_occ}, 32'd1);
      chk("t6_in_ready", {31'd0, n_in_ready}, 32'd1);
    end
    n_in_valid = 1'b0;
    cyc1();
    chk("t6_drain_occ", {30'd0, n_occ}, 32'd0);
    chk("t6_sb_empty", sb1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
